iseq_arbiter: RTL and testbench

ISEQ_ARBITER -- requirements
Module: iseq_arbiter

---
 rtl/iseq_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_iseq_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iseq_arbiter.sv
// ============================================================================
// Module      : iseq_arbiter
// Description : Two-port round-robin arbiter that hands the controller command
//               interface to one requester for a whole instruction sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iseq_arbiter #(
  parameter logic [3:0] OPC_END       = 4'b0000,
  parameter int         START_TIMEOUT = 16,
  parameter int         CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_en,
  input  logic [31:0]          m0_instr,
  output logic                 m0_ack,
  input  logic                 m1_en,
  input  logic [31:0]          m1_instr,
  output logic                 m1_ack,
  output logic                 app_en,
  output logic [31:0]          app_instr,
  input  logic                 app_ack,
  input  logic                 iq_full,
  input  logic                 processing_iseq,
  output logic [1:0]           grant,
  output logic [1:0]           seq_done,
  output logic [CNT_WIDTH-1:0] seq_cnt0,
  output logic [CNT_WIDTH-1:0] seq_cnt1,
  output logic                 start_timeout_err
);

  localparam int                c_TMO_W    = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LOAD = c_TMO_W'(START_TIMEOUT);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GRANT0     = 3'd1,
    S_GRANT1     = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_served;
  logic [c_TMO_W-1:0]   r_tmo;
  logic [1:0]           r_grant;
  logic [1:0]           r_seq_done;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;
  logic                 r_err;

  logic                 w_app_en;
  logic [31:0]          w_app_instr;
  logic                 w_m0_ack;
  logic                 w_m1_ack;
  logic                 w_xfer_end;
  logic                 w_tmo_fire;
  logic                 w_complete;

  always_comb begin
    w_state_nxt = r_state;
    w_app_en    = 1'b0;
    w_app_instr = 32'h0;
    w_m0_ack    = 1'b0;
    w_m1_ack    = 1'b0;
    w_xfer_end  = 1'b0;
    w_tmo_fire  = 1'b0;
    w_complete  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A controller-internal sequence blocks new grants entirely.
        if (!processing_iseq) begin
          if (m0_en && m1_en) begin
            w_state_nxt = r_last_served ? S_GRANT0 : S_GRANT1;
          end else if (m0_en) begin
            w_state_nxt = S_GRANT0;
          end else if (m1_en) begin
            w_state_nxt = S_GRANT1;
          end
        end
      end

      S_GRANT0: begin
        w_app_en    = m0_en & ~iq_full;
        w_app_instr = w_app_en ? m0_instr : 32'h0;
        w_m0_ack    = app_ack & w_app_en;
        if (w_m0_ack && (m0_instr[31:28] == OPC_END)) begin
          w_xfer_end  = 1'b1;
          w_state_nxt = S_WAIT_START;
        end
      end

      S_GRANT1: begin
        w_app_en    = m1_en & ~iq_full;
        w_app_instr = w_app_en ? m1_instr : 32'h0;
        w_m1_ack    = app_ack & w_app_en;
        if (w_m1_ack && (m1_instr[31:28] == OPC_END)) begin
          w_xfer_end  = 1'b1;
          w_state_nxt = S_WAIT_START;
        end
      end

      S_WAIT_START: begin
        if (processing_iseq) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_tmo <= c_TMO_ONE) begin
          w_tmo_fire  = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_WAIT_DONE: begin
        if (!processing_iseq) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_served <= 1'b1;
      r_tmo         <= '0;
      r_grant       <= 2'b00;
      r_seq_done    <= 2'b00;
      r_cnt0        <= '0;
      r_cnt1        <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= {w_state_nxt == S_GRANT1, w_state_nxt == S_GRANT0};
      r_seq_done <= 2'b00;

      if (w_xfer_end) begin
        r_last_served <= (r_state == S_GRANT1);
        r_tmo         <= c_TMO_LOAD;
      end else if (r_state == S_WAIT_START) begin
        r_tmo <= (w_state_nxt == S_WAIT_START) ? (r_tmo - c_TMO_ONE) : '0;
      end

      if (w_tmo_fire) begin
        r_err <= 1'b1;
      end

      if (w_complete) begin
        if (r_last_served) begin
          r_seq_done <= 2'b10;
          r_cnt1     <= r_cnt1 + c_CNT_ONE;
        end else begin
          r_seq_done <= 2'b01;
          r_cnt0     <= r_cnt0 + c_CNT_ONE;
        end
      end
    end
  end

  assign app_en            = w_app_en;
  assign app_instr         = w_app_instr;
  assign m0_ack            = w_m0_ack;
  assign m1_ack            = w_m1_ack;
  assign grant             = r_grant;
  assign seq_done          = r_seq_done;
  assign seq_cnt0          = r_cnt0;
  assign seq_cnt1          = r_cnt1;
  assign start_timeout_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_iseq_arbiter.sv
// ============================================================================
// Module      : tb_iseq_arbiter
// Description : Directed vector table plus multi-cycle sequences for iseq_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iseq_arbiter;

  localparam logic [31:0] I1 = 32'h1000_00A1;
  localparam logic [31:0] I2 = 32'h2000_00A2;
  localparam logic [31:0] E0 = 32'h0000_00E0;
  localparam logic [31:0] J1 = 32'h3000_00B1;
  localparam logic [31:0] J2 = 32'h4000_00B2;
  localparam logic [31:0] E1 = 32'h0000_00E1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_en = 1'b0, m1_en = 1'b0;
  logic [31:0] m0_instr = 32'h0, m1_instr = 32'h0;
  logic        app_ack = 1'b0, iq_full = 1'b0, processing_iseq = 1'b0;
  logic        m0_ack, m1_ack, app_en, start_timeout_err;
  logic [31:0] app_instr;
  logic [1:0]  grant, seq_done;
  logic [15:0] seq_cnt0, seq_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  iseq_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m0_en             (m0_en),
    .m0_instr          (m0_instr),
    .m0_ack            (m0_ack),
    .m1_en             (m1_en),
    .m1_instr          (m1_instr),
    .m1_ack            (m1_ack),
    .app_en            (app_en),
    .app_instr         (app_instr),
    .app_ack           (app_ack),
    .iq_full           (iq_full),
    .processing_iseq   (processing_iseq),
    .grant             (grant),
    .seq_done          (seq_done),
    .seq_cnt0          (seq_cnt0),
    .seq_cnt1          (seq_cnt1),
    .start_timeout_err (start_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0e;
    logic [31:0] m0i;
    logic        m1e;
    logic [31:0] m1i;
    logic        ack;
    logic        full;
    logic        proc;
    logic [1:0]  x_grant;
    logic        x_m0a;
    logic        x_m1a;
    logic        x_aen;
    logic [31:0] x_ainstr;
    logic [1:0]  x_done;
    logic [15:0] x_cnt0;
    logic [15:0] x_cnt1;
    logic        x_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic m0e, input logic [31:0] m0i, input logic m1e,
                              input logic [31:0] m1i, input logic ack, input logic full,
                              input logic proc, input logic [1:0] g, input logic m0a,
                              input logic m1a, input logic aen, input logic [31:0] ai,
                              input logic [1:0] d, input logic [15:0] c0, input logic [15:0] c1,
                              input logic e);
    vec_t v;
    v.m0e = m0e; v.m0i = m0i; v.m1e = m1e; v.m1i = m1i;
    v.ack = ack; v.full = full; v.proc = proc;
    v.x_grant = g; v.x_m0a = m0a; v.x_m1a = m1a; v.x_aen = aen; v.x_ainstr = ai;
    v.x_done = d; v.x_cnt0 = c0; v.x_cnt1 = c1; v.x_err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m0e, input logic [31:0] m0i, input logic m1e,
                       input logic [31:0] m1i, input logic ack, input logic full,
                       input logic proc);
    m0_en = m0e; m0_instr = m0i; m1_en = m1e; m1_instr = m1i;
    app_ack = ack; iq_full = full; processing_iseq = proc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] snap();
    return {grant, m0_ack, m1_ack, app_en, app_instr, seq_done, seq_cnt0, seq_cnt1, start_timeout_err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order[$];
    logic [1:0] exp_order[4];
    logic [1:0] prev_g;
    int p0, p1, proc_cnt, done_seqs, cyc;

    // Single-port sequence, iq_full stall with a competing port, then a port-1 END.
    tbl.push_back(mk(1, I1, 0, 0,  1, 0, 0,  2'b00, 0, 0, 0, 0,  2'b00, 0, 0, 0));
    tbl.push_back(mk(1, I1, 0, 0,  1, 0, 0,  2'b01, 1, 0, 1, I1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, I2, 0, 0,  1, 0, 0,  2'b01, 1, 0, 1, I2, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, E0, 0, 0,  1, 0, 0,  2'b01, 1, 0, 1, E0, 2'b00, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  2'b00, 0, 0, 0, 0,  2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0,  1, 0, 0,  2'b00, 0, 0, 0, 0,  2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0, 0,  0, 0, 0,  2'b00, 0, 0, 0, 0,  2'b01, 1, 0, 0));
    tbl.push_back(mk(1, I1, 0, 0,  1, 0, 0,  2'b00, 0, 0, 0, 0,  2'b00, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, I1, 1, J1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(1, I1, 1, J1, 1, 0, 0,  2'b01, 1, 0, 1, I1, 2'b00, 1, 0, 0));
    tbl.push_back(mk(1, E0, 1, J1, 1, 0, 0,  2'b01, 1, 0, 1, E0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 0,  1, J1, 1, 0, 1,  2'b00, 0, 0, 0, 0,  2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 0,  1, J1, 1, 0, 0,  2'b00, 0, 0, 0, 0,  2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 0,  1, E1, 1, 0, 0,  2'b00, 0, 0, 0, 0,  2'b01, 2, 0, 0));
    tbl.push_back(mk(0, 0,  1, E1, 1, 0, 0,  2'b10, 0, 1, 1, E1, 2'b00, 2, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].m0e, tbl[i].m0i, tbl[i].m1e, tbl[i].m1i, tbl[i].ack, tbl[i].full, tbl[i].proc);
      @(negedge clk);
      chk($sformatf("vec%0d", i), snap(),
          {tbl[i].x_grant, tbl[i].x_m0a, tbl[i].x_m1a, tbl[i].x_aen, tbl[i].x_ainstr,
           tbl[i].x_done, tbl[i].x_cnt0, tbl[i].x_cnt1, tbl[i].x_err});
      next_cycle();
    end

    // Start timeout: port 1 END accepted, processing_iseq never rises.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_wait%0d", i), {grant, start_timeout_err, seq_done}, {2'b00, 1'b0, 2'b00});
      next_cycle();
    end
    drive(1, E0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("tmo_fire", {start_timeout_err, seq_done, seq_cnt1}, {1'b1, 2'b10, 16'd1});
    next_cycle();
    @(negedge clk);
    chk("tmo_next_grant", {grant, m0_ack, app_instr}, {2'b01, 1'b1, E0});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("tmo_after", {seq_done, seq_cnt0, start_timeout_err}, {2'b01, 16'd3, 1'b1});

    // Reset in the middle of a port-1 sequence.
    do_reset();
    drive(0, 0, 1, J1, 1, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_m1_first", {grant, m1_ack, app_instr}, {2'b10, 1'b1, J1});
    next_cycle();
    drive(0, 0, 1, J2, 1, 0, 0);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drive(1, E0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst_abandon", {grant, m0_ack, seq_done, seq_cnt1, start_timeout_err},
        {2'b00, 1'b0, 2'b00, 16'd0, 1'b0});
    next_cycle();
    @(negedge clk);
    chk("rst_m0_served", {grant, m0_ack, app_instr}, {2'b01, 1'b1, E0});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_m0_done", {seq_done, seq_cnt0, seq_cnt1}, {2'b01, 16'd1, 16'd0});
    next_cycle();

    // processing_iseq high in IDLE holds off a grant.
    for (int i = 0; i < 4; i++) begin
      drive(1, E0, 0, 0, 1, 0, 1);
      @(negedge clk);
      chk($sformatf("busy_hold%0d", i), {grant, m0_ack, app_en}, {2'b00, 1'b0, 1'b0});
      next_cycle();
    end
    drive(1, E0, 0, 0, 1, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("busy_release", {grant, m0_ack, app_instr}, {2'b01, 1'b1, E0});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("busy_done", {seq_done, seq_cnt0}, {2'b01, 16'd2});
    next_cycle();

    // Both ports requesting continuously: round-robin over two sequences each.
    do_reset();
    prev_g = 2'b00; p0 = 0; p1 = 0; proc_cnt = 0; done_seqs = 0; cyc = 0;
    while (done_seqs < 4 && cyc < 400) begin
      m0_en = 1'b1; m1_en = 1'b1;
      m0_instr = (p0 % 2 == 1) ? E0 : I1;
      m1_instr = (p1 % 2 == 1) ? E1 : J1;
      app_ack = 1'b1; iq_full = 1'b0;
      processing_iseq = (proc_cnt > 0);
      if (proc_cnt > 0) proc_cnt--;
      @(negedge clk);
      if (grant != 2'b00 && prev_g == 2'b00) order.push_back(grant);
      prev_g = grant;
      if (seq_done != 2'b00) done_seqs++;
      if (m0_ack) begin
        if (m0_instr[31:28] == 4'h0) proc_cnt = 2;
        p0++;
      end
      if (m1_ack) begin
        if (m1_instr[31:28] == 4'h0) proc_cnt = 2;
        p1++;
      end
      next_cycle();
      cyc++;
    end
    chk("rr_completed", done_seqs, 4);
    chk("rr_grants", order.size(), 4);
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    end
    chk("rr_counts", {seq_cnt0, seq_cnt1}, {16'd2, 16'd2});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
